// File: rtl/dti_fifo_pkg.sv
// Shared defaults for the dti_fifo block: geometry used when the
// instantiating code does not override it.
package dti_fifo_pkg;

   localparam int DTI_FIFO_DEPTH_DEF = 4;
   localparam int DTI_FIFO_DIN_DEF   = 16;

endpackage : dti_fifo_pkg

// File: rtl/dti.sv
// Valid/ready handshake bundle: producer drives data/valid, consumer drives ready.
interface dti #(
   parameter int W_DATA = 16
);
   logic [W_DATA-1:0] data;
   logic              valid;
   logic              ready;

   modport producer (output data, output valid, input ready);
   modport consumer (input data, input valid, output ready);
endinterface : dti

// File: rtl/dti_fifo.sv
// Circular-buffer FIFO on the dti handshake; input ready depends only on
// registered occupancy, and output data always comes from storage.
module dti_fifo
   import dti_fifo_pkg::*;
#(
   parameter int DEPTH = DTI_FIFO_DEPTH_DEF,
   parameter int DIN   = DTI_FIFO_DIN_DEF
) (
   input logic  clk,
   input logic  rst,
   dti.consumer din,
   dti.producer dout
);

   localparam int AW = $clog2(DEPTH);

   logic [DIN-1:0] r_mem [DEPTH];
   logic [AW:0]    r_wr_ptr;
   logic [AW:0]    r_rd_ptr;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;

   // The extra pointer MSB separates "same slot, lapped" (full) from "same slot" (empty).
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);

   assign w_push = din.valid && din.ready;
   assign w_pop  = dout.valid && dout.ready;

   assign din.ready  = !w_full && !rst;
   assign dout.valid = !w_empty;
   assign dout.data  = r_mem[r_rd_ptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; cleared pointers already mark it empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din.data;
   end

endmodule : dti_fifo

// File: tb/tb_dti_fifo.sv
// Directed + random bench for dti_fifo: a queue model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_dti_fifo;

   localparam int DEPTH = 4;
   localparam int DIN   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   dti #(.W_DATA(DIN)) din_if ();
   dti #(.W_DATA(DIN)) dout_if ();

   dti_fifo #(.DEPTH(DEPTH), .DIN(DIN)) dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din_if),
      .dout (dout_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of accepted words, capacity DEPTH.
   logic [DIN-1:0] model_q[$];
   bit             started = 1'b0;

   always @(posedge clk) begin
      bit do_push;
      bit do_pop;
      started = 1'b1;
      if (rst) begin
         model_q.delete();
      end else begin
         do_push = din_if.valid && (model_q.size() < DEPTH);
         do_pop  = (model_q.size() > 0) && dout_if.ready;
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back(din_if.data);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("model_din_ready", 32'(din_if.ready), 32'(!rst && (model_q.size() < DEPTH)));
         check("model_dout_valid", 32'(dout_if.valid), 32'(model_q.size() > 0));
         if (model_q.size() > 0)
            check("model_dout_data", 32'(dout_if.data), 32'(model_q[0]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [DIN-1:0] d);
      din_if.valid = 1'b1;
      din_if.data  = d;
      tick();
      din_if.valid = 1'b0;
   endtask

   initial begin
      din_if.valid  = 1'b1;
      din_if.data   = 16'hDEAD;
      dout_if.ready = 1'b0;

      // Reset held two cycles with valid asserted: nothing accepted.
      rst = 1'b1;
      tick();
      tick();
      check("rst_din_ready", 32'(din_if.ready), 32'd0);
      check("rst_dout_valid", 32'(dout_if.valid), 32'd0);
      rst = 1'b0;
      din_if.valid = 1'b0;
      #1;
      check("post_rst_din_ready", 32'(din_if.ready), 32'd1);
      check("post_rst_empty", 32'(dout_if.valid), 32'd0);

      // Single word, held through stalls, then popped.
      push_word(16'h1234);
      check("single_valid", 32'(dout_if.valid), 32'd1);
      check("single_data", 32'(dout_if.data), 32'h1234);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("single_stall_data", 32'(dout_if.data), 32'h1234);
      end
      dout_if.ready = 1'b1;
      tick();
      dout_if.ready = 1'b0;
      check("single_popped", 32'(dout_if.valid), 32'd0);

      // Fill to capacity; a fifth word is refused.
      for (int k = 0; k < 4; k++) begin
         din_if.valid = 1'b1;
         din_if.data  = 16'(16'hA0 + k);
         tick();
      end
      check("fill_full", 32'(din_if.ready), 32'd0);
      din_if.data = 16'hA4;
      repeat (3) tick();
      check("fill_still_full", 32'(din_if.ready), 32'd0);
      din_if.valid  = 1'b0;
      dout_if.ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("drain_valid", 32'(dout_if.valid), 32'd1);
         check("drain_data", 32'(dout_if.data), 32'(16'hA0 + k));
         tick();
         if (k == 0) check("drain_ready_rise", 32'(din_if.ready), 32'd1);
      end
      check("drain_empty", 32'(dout_if.valid), 32'd0);

      // Streaming with constant ready: each word visible one cycle after its push.
      for (int k = 0; k < 20; k++) begin
         din_if.valid = 1'b1;
         din_if.data  = 16'(k);
         tick();
         check("stream_valid", 32'(dout_if.valid), 32'd1);
         check("stream_data", 32'(dout_if.data), 32'(k));
      end
      din_if.valid = 1'b0;
      tick();
      check("stream_empty", 32'(dout_if.valid), 32'd0);

      // Simultaneous push and pop at occupancy 2.
      dout_if.ready = 1'b0;
      push_word(16'h10);
      push_word(16'h11);
      dout_if.ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         din_if.valid = 1'b1;
         din_if.data  = 16'(16'h12 + k);
         tick();
         check("pp_head", 32'(dout_if.data), 32'(16'h11 + k));
         check("pp_not_full", 32'(din_if.ready), 32'd1);
      end
      din_if.valid = 1'b0;
      repeat (3) tick();
      check("pp_drained", 32'(dout_if.valid), 32'd0);

      // Random traffic; the per-cycle model comparison does the checking.
      for (int k = 0; k < 1000; k++) begin
         din_if.valid  = 1'($urandom_range(0, 1));
         din_if.data   = 16'($urandom);
         dout_if.ready = 1'($urandom_range(0, 1));
         tick();
      end
      din_if.valid  = 1'b0;
      dout_if.ready = 1'b1;
      repeat (DEPTH + 2) tick();
      check("rand_drained", 32'(dout_if.valid), 32'd0);

      // Reset with three words stored discards them all.
      dout_if.ready = 1'b0;
      push_word(16'h31);
      push_word(16'h32);
      push_word(16'h33);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_empty", 32'(dout_if.valid), 32'd0);
      push_word(16'h55);
      check("midrst_valid", 32'(dout_if.valid), 32'd1);
      check("midrst_data", 32'(dout_if.data), 32'h55);
      dout_if.ready = 1'b1;
      tick();
      dout_if.ready = 1'b0;
      check("midrst_only", 32'(dout_if.valid), 32'd0);

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_dti_fifo
